lut_func_unit: RTL and testbench



---
 rtl/lut_func_unit_if.sv | 29 ++
 rtl/lut_func_unit.sv | 122 ++++++++++++
 tb/tb_lut_func_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_func_unit_if.sv
// rtl/lut_func_unit_if.sv - evaluation and truth-table load bus for lut_func_unit
interface lut_func_unit_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic             F;
  logic             Fn;
  logic             cfg_start;
  logic             cfg_abort;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic             cfg_done;
  logic             busy;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output in_valid, in_vec, cfg_start, cfg_abort, cfg_valid, cfg_bit,
    input  out_valid, F, Fn, cfg_ready, cfg_done, busy, hit_cnt
  );

  modport slave (
    input  in_valid, in_vec, cfg_start, cfg_abort, cfg_valid, cfg_bit,
    output out_valid, F, Fn, cfg_ready, cfg_done, busy, hit_cnt
  );
endinterface

// File: rtl/lut_func_unit.sv
// rtl/lut_func_unit.sv - registered N-input LUT evaluator with serial shadow-table load
module lut_func_unit #(
  parameter int                  N_IN  = 3,
  parameter logic [2**N_IN-1:0]  INIT  = 8'h5C,
  parameter int                  CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  lut_func_unit_if.slave bus
);
  localparam int M    = 2**N_IN;
  localparam int BC_W = $clog2(M) + 1;
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     table_q, table_d;
  logic [M-1:0]     shadow_q, shadow_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             f_q, f_d;
  logic             fn_q, fn_d;
  logic             out_valid_q, out_valid_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_done_q, cfg_done_d;
  logic             busy_q, busy_d;
  logic             commit;
  logic             lut_bit;

  always_comb begin
    state_d   = state_q;
    table_d   = table_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    commit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          shadow_d  = '0;
        end
      end
      S_LOAD: begin
        // Abort takes priority so a final bit arriving with it never commits.
        if (bus.cfg_abort) begin
          state_d   = S_IDLE;
          shadow_d  = '0;
          bit_cnt_d = '0;
        end else if (bus.cfg_valid) begin
          shadow_d  = {shadow_q[M-2:0], bus.cfg_bit};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        table_d = shadow_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluation reads the pre-edge table, so a commit never affects the same-edge result.
    lut_bit     = table_q[bus.in_vec];
    out_valid_d = bus.in_valid;
    f_d         = bus.in_valid ? lut_bit : f_q;
    fn_d        = ~f_d;

    hit_cnt_d = hit_cnt_q;
    if (commit) begin
      hit_cnt_d = '0;
    end else if (bus.in_valid && lut_bit && (hit_cnt_q != CNT_MAX)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    cfg_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    cfg_done_d  = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      table_q     <= INIT;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      f_q         <= 1'b0;
      fn_q        <= 1'b1;
      out_valid_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      f_q         <= f_d;
      fn_q        <= fn_d;
      out_valid_q <= out_valid_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.F         = f_q;
  assign bus.Fn        = fn_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.busy      = busy_q;
  assign bus.hit_cnt   = hit_cnt_q;
endmodule

// File: tb/tb_lut_func_unit.sv
// tb/tb_lut_func_unit.sv - scoreboard bench for lut_func_unit
module tb_lut_func_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lut_func_unit_if #(.N_IN(3), .CNT_W(8)) ia ();
  lut_func_unit_if #(.N_IN(3), .CNT_W(2)) ib ();

  lut_func_unit #(.N_IN(3), .INIT(8'h5C), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  lut_func_unit #(.N_IN(3), .INIT(8'h5C), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  localparam logic [7:0] INIT_TAB = 8'h5C;

  int   checks = 0;
  int   errors = 0;
  bit   exp_a[$];
  bit   exp_b[$];
  logic [7:0] tab_a;
  logic [7:0] tab_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ia.out_valid === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_out actual=1 required=0");
      end else begin
        bit e;
        bit ne;
        e  = exp_a.pop_front();
        ne = !e;
        chk("a_F", ia.F, e);
        chk("a_Fn", ia.Fn, ne);
      end
    end
  end

  always @(negedge clk) begin
    if (ib.out_valid === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_out actual=1 required=0");
      end else begin
        bit e;
        bit ne;
        e  = exp_b.pop_front();
        ne = !e;
        chk("b_F", ib.F, e);
        chk("b_Fn", ib.Fn, ne);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cycle();
    tick();
    ia.in_valid  = 1'b0;
    ia.cfg_start = 1'b0;
    ia.cfg_abort = 1'b0;
    ia.cfg_valid = 1'b0;
  endtask

  task automatic b_cycle();
    tick();
    ib.in_valid  = 1'b0;
    ib.cfg_start = 1'b0;
    ib.cfg_abort = 1'b0;
    ib.cfg_valid = 1'b0;
  endtask

  task automatic a_eval(input logic [2:0] v);
    ia.in_valid = 1'b1;
    ia.in_vec   = v;
    exp_a.push_back(tab_a[v]);
  endtask

  task automatic b_eval(input logic [2:0] v);
    ib.in_valid = 1'b1;
    ib.in_vec   = v;
    exp_b.push_back(tab_b[v]);
  endtask

  task automatic a_bit(input logic b);
    ia.cfg_valid = 1'b1;
    ia.cfg_bit   = b;
  endtask

  task automatic a_sweep();
    for (int v = 0; v < 8; v++) begin
      a_eval(3'(v));
      a_cycle();
    end
  endtask

  initial begin
    logic [7:0] and3_bits;
    rst_n = 1'b0;
    tab_a = INIT_TAB;
    tab_b = INIT_TAB;
    ia.in_valid = 0; ia.in_vec = 0; ia.cfg_start = 0; ia.cfg_abort = 0; ia.cfg_valid = 0; ia.cfg_bit = 0;
    ib.in_valid = 0; ib.in_vec = 0; ib.cfg_start = 0; ib.cfg_abort = 0; ib.cfg_valid = 0; ib.cfg_bit = 0;

    repeat (3) tick();
    chk("rst_F", ia.F, 0);
    chk("rst_Fn", ia.Fn, 1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_cfg_ready", ia.cfg_ready, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_cfg_done", ia.cfg_done, 0);
    chk("rst_hit_cnt", ia.hit_cnt, 0);

    rst_n = 1'b1;
    a_cycle();
    a_cycle();
    chk("pre_eval_F", ia.F, 0);
    chk("pre_eval_Fn", ia.Fn, 1);

    a_sweep();
    a_cycle();
    chk("idle_out_valid", ia.out_valid, 0);
    chk("init_hit_cnt", ia.hit_cnt, 4);

    // Abort after five bits: table must stay INIT.
    ia.cfg_start = 1'b1;
    a_cycle();
    chk("load_cfg_ready", ia.cfg_ready, 1);
    chk("load_busy", ia.busy, 1);
    for (int i = 0; i < 5; i++) begin
      a_bit(1'b1);
      a_cycle();
    end
    ia.cfg_abort = 1'b1;
    a_bit(1'b1);
    a_cycle();
    chk("abort5_busy", ia.busy, 0);
    chk("abort5_cfg_ready", ia.cfg_ready, 0);
    chk("abort5_cfg_done", ia.cfg_done, 0);
    a_cycle();
    chk("abort5_cfg_done_late", ia.cfg_done, 0);
    a_sweep();

    // Abort coincident with the last bit.
    ia.cfg_start = 1'b1;
    a_cycle();
    for (int i = 0; i < 7; i++) begin
      a_bit(1'b1);
      a_cycle();
    end
    ia.cfg_abort = 1'b1;
    a_bit(1'b1);
    a_cycle();
    chk("abort8_busy", ia.busy, 0);
    chk("abort8_cfg_done", ia.cfg_done, 0);
    a_cycle();
    chk("abort8_cfg_done_late", ia.cfg_done, 0);
    a_eval(3'd0);
    a_cycle();
    a_eval(3'd7);
    a_cycle();

    // AND3 load with stalls and an evaluation mid-load.
    and3_bits = 8'b1000_0000;
    ia.cfg_start = 1'b1;
    a_cycle();
    for (int i = 0; i < 8; i++) begin
      a_bit(and3_bits[7-i]);
      if (i == 4) a_eval(3'd2);
      a_cycle();
      if (i == 1 || i == 5) begin
        a_cycle();
        chk("stall_busy", ia.busy, 1);
      end
    end
    chk("last_accept_cfg_done", ia.cfg_done, 0);
    chk("commit_busy", ia.busy, 1);
    chk("commit_cfg_ready", ia.cfg_ready, 0);
    a_eval(3'd2);
    a_cycle();
    chk("commit_cfg_done", ia.cfg_done, 1);
    chk("commit_busy_low", ia.busy, 0);
    chk("commit_hit_clear", ia.hit_cnt, 0);
    tab_a = 8'h80;
    a_eval(3'd2);
    a_cycle();
    chk("done_pulse_end", ia.cfg_done, 0);
    a_sweep();
    chk("and3_hit_cnt", ia.hit_cnt, 1);

    // Asynchronous reset in the middle of a load.
    ia.cfg_start = 1'b1;
    a_cycle();
    a_bit(1'b1);
    a_cycle();
    a_bit(1'b0);
    a_cycle();
    a_bit(1'b1);
    ia.in_valid = 1'b1;
    ia.in_vec   = 3'd7;
    tick();
    chk("prereset_F", ia.F, 1);
    chk("prereset_hit_cnt", ia.hit_cnt, 2);
    ia.in_valid = 1'b0;
    ia.cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_F", ia.F, 0);
    chk("async_Fn", ia.Fn, 1);
    chk("async_out_valid", ia.out_valid, 0);
    chk("async_busy", ia.busy, 0);
    chk("async_cfg_ready", ia.cfg_ready, 0);
    chk("async_hit_cnt", ia.hit_cnt, 0);
    a_cycle();
    rst_n = 1'b1;
    a_cycle();
    chk("post_reset_cfg_ready", ia.cfg_ready, 0);
    chk("post_reset_busy", ia.busy, 0);
    tab_a = INIT_TAB;
    a_sweep();

    // Saturating 2-bit counter, then clear on commit.
    b_eval(3'd2);
    b_cycle();
    b_eval(3'd3);
    b_cycle();
    chk("b_hit_cnt_2", ib.hit_cnt, 2);
    b_eval(3'd4);
    b_cycle();
    b_eval(3'd6);
    b_cycle();
    b_eval(3'd2);
    b_cycle();
    chk("b_hit_cnt_sat", ib.hit_cnt, 3);
    ib.cfg_start = 1'b1;
    b_cycle();
    for (int i = 0; i < 8; i++) begin
      ib.cfg_valid = 1'b1;
      ib.cfg_bit   = 1'b1;
      b_cycle();
    end
    b_eval(3'd2);
    b_cycle();
    chk("b_commit_cfg_done", ib.cfg_done, 1);
    chk("b_commit_hit_clear", ib.hit_cnt, 0);
    tab_b = 8'hFF;
    b_eval(3'd0);
    b_cycle();
    chk("b_new_table_hit", ib.hit_cnt, 1);

    a_cycle();
    a_cycle();
    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
